// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_N_DEFAULT = 4;
  localparam int ARB_HOLD_W    = 8;

endpackage

// File: rtl/grant_decoder.sv
// Binary-to-one-hot decoder with enable, built as a tree of 1-to-2 stages.
// Purely combinational, zero latency, no flow control.
module decoder_1_to_2 (
  input  logic       en,
  input  logic       sel,
  output logic [1:0] y
);

  assign y[0] = en & ~sel;
  assign y[1] = en &  sel;

endmodule

module grant_decoder
  import arb_pkg::*;
#(
  parameter int N = ARB_N_DEFAULT
) (
  input  logic                 en,
  input  logic [$clog2(N)-1:0] id,
  output logic [N-1:0]         onehot
);

  localparam int IW = $clog2(N);

  // Heap-ordered tree: node k feeds nodes 2k+1 and 2k+2; leaves are N-1..2N-2.
  logic [2*N-2:0] node_en;

  assign node_en[0] = en;

  for (genvar l = 0; l < IW; l++) begin : g_level
    for (genvar j = 0; j < (1 << l); j++) begin : g_node
      localparam int K = (1 << l) - 1 + j;
      decoder_1_to_2 u_dec (
        .en  (node_en[K]),
        .sel (id[IW-1-l]),
        .y   (node_en[2*K+2:2*K+1])
      );
    end
  end

  assign onehot = node_en[2*N-2:N-1];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, 1-cycle grant latency; ena=0 masks gnt and freezes all state.
// Optional hold-timeout forced rotation under `ARB_TIMEOUT_EN; default build has none.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N_DEFAULT,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 gnt_valid,
  output logic                 timeout
);

  localparam int IW = $clog2(N);

  if (!(N == 2 || N == 4 || N == 8)) begin : g_bad_n
    $error("rr_arbiter: N must be 2, 4 or 8");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("rr_arbiter: MAX_HOLD must be in 2..255");
  end

  arb_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;

  logic [N-1:0]  owner_oh;
  logic [N-1:0]  others;
  logic [N-1:0]  cand;
  logic [IW-1:0] idx;
  logic [IW-1:0] win_id;
  logic          win_found;
  logic          release_own;
  logic          forced_rot;
  logic          new_grant;
  logic          hold_expired;

  always_comb begin
    owner_oh           = '0;
    owner_oh[gnt_id_q] = 1'b1;
    others             = req & ~owner_oh;
    // While granted the owner never competes, so a same-cycle drop/re-raise counts as a release.
    cand               = (state_q == ARB_GRANT) ? others : req;

    idx       = '0;
    win_id    = '0;
    win_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = ptr_q + IW'(i);
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end

    release_own = ~req[gnt_id_q];
    forced_rot  = ena && (state_q == ARB_GRANT) && !release_own && hold_expired && (|others);

    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    new_grant = 1'b0;

    if (ena) begin
      case (state_q)
        ARB_IDLE: begin
          if (win_found) begin
            state_d   = ARB_GRANT;
            new_grant = 1'b1;
          end
        end
        ARB_GRANT: begin
          if (release_own || forced_rot) begin
            if (win_found) begin
              new_grant = 1'b1;
            end else begin
              state_d = ARB_IDLE;
            end
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end

    if (new_grant) begin
      gnt_id_d = win_id;
      ptr_d    = win_id + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      gnt_id_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_id_q <= gnt_id_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [ARB_HOLD_W-1:0] HOLD_LAST = ARB_HOLD_W'(MAX_HOLD - 1);

  logic [ARB_HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic                  timeout_q, timeout_d;

  // Counter parks at HOLD_LAST, so a late competitor rotates on its first cycle.
  assign hold_expired = (hold_cnt_q == HOLD_LAST);

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    timeout_d  = forced_rot;
    if (new_grant) begin
      hold_cnt_d = '0;
    end else if (ena && (state_q == ARB_GRANT) && !hold_expired) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  assign gnt_valid = (state_q == ARB_GRANT);
  assign gnt_id    = gnt_id_q;

  grant_decoder #(
    .N (N)
  ) u_grant_decoder (
    .en     (gnt_valid & ena),
    .id     (gnt_id_q),
    .onehot (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter.sv
// Table-driven bench for rr_arbiter with a scoreboard of expected post-edge outputs.
module tb_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  always #5 clk = ~clk;

  rr_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       valid;
    logic       to;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       ena;
    logic [3:0] req;
    exp_t       exp;
  } vec_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t ex(logic [3:0] g, logic [1:0] id, logic v, logic t);
    exp_t e;
    e.gnt   = g;
    e.id    = id;
    e.valid = v;
    e.to    = t;
    return e;
  endfunction

  function automatic vec_t mk(logic r, logic e, logic [3:0] q, exp_t x);
    vec_t v;
    v.rst = r;
    v.ena = e;
    v.req = q;
    v.exp = x;
    return v;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // Drive one cycle of stimulus, then compare the DUT against the queued expectation.
  task automatic step(string tag, logic r, logic e, logic [3:0] q, exp_t x);
    exp_t want;
    rst = r;
    ena = e;
    req = q;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    want = sb_q.pop_front();
    chk({tag, ".gnt"},       {4'b0, gnt},       {4'b0, want.gnt});
    chk({tag, ".gnt_id"},    {6'b0, gnt_id},    {6'b0, want.id});
    chk({tag, ".gnt_valid"}, {7'b0, gnt_valid}, {7'b0, want.valid});
    chk({tag, ".timeout"},   {7'b0, timeout},   {7'b0, want.to});
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b0;
    req = 4'b0000;

    vecs.push_back(mk(1, 1, 4'b0000, ex(4'b0000, 2'd0, 0, 0)));  // reset state
    vecs.push_back(mk(1, 1, 4'b1010, ex(4'b0000, 2'd0, 0, 0)));  // reset beats req
    vecs.push_back(mk(0, 1, 4'b1010, ex(4'b0010, 2'd1, 1, 0)));  // first grant from 0
    vecs.push_back(mk(0, 1, 4'b1010, ex(4'b0010, 2'd1, 1, 0)));
    vecs.push_back(mk(0, 1, 4'b1000, ex(4'b1000, 2'd3, 1, 0)));  // handoff, no gap
    vecs.push_back(mk(0, 1, 4'b0001, ex(4'b0001, 2'd0, 1, 0)));  // wrap 3 -> 0
    vecs.push_back(mk(0, 1, 4'b0000, ex(4'b0000, 2'd0, 0, 0)));  // release to idle
    vecs.push_back(mk(0, 1, 4'b0000, ex(4'b0000, 2'd0, 0, 0)));
    vecs.push_back(mk(0, 0, 4'b0100, ex(4'b0000, 2'd0, 0, 0)));  // ena=0 blocks grant
    vecs.push_back(mk(1, 1, 4'b1111, ex(4'b0000, 2'd0, 0, 0)));
    vecs.push_back(mk(0, 1, 4'b1111, ex(4'b0001, 2'd0, 1, 0)));  // order 0,1,2,3,0
    vecs.push_back(mk(0, 1, 4'b1110, ex(4'b0010, 2'd1, 1, 0)));
    vecs.push_back(mk(0, 1, 4'b1101, ex(4'b0100, 2'd2, 1, 0)));
    vecs.push_back(mk(0, 1, 4'b1011, ex(4'b1000, 2'd3, 1, 0)));
    vecs.push_back(mk(0, 1, 4'b0111, ex(4'b0001, 2'd0, 1, 0)));
    vecs.push_back(mk(0, 1, 4'b0001, ex(4'b0001, 2'd0, 1, 0)));
    vecs.push_back(mk(0, 0, 4'b0001, ex(4'b0000, 2'd0, 1, 0)));  // ena low 3 cycles
    vecs.push_back(mk(0, 0, 4'b0001, ex(4'b0000, 2'd0, 1, 0)));
    vecs.push_back(mk(0, 0, 4'b0001, ex(4'b0000, 2'd0, 1, 0)));
    vecs.push_back(mk(0, 1, 4'b0001, ex(4'b0001, 2'd0, 1, 0)));  // grant restored
    vecs.push_back(mk(1, 1, 4'b0001, ex(4'b0000, 2'd0, 0, 0)));  // reset mid-tenure
    vecs.push_back(mk(0, 1, 4'b0100, ex(4'b0100, 2'd2, 1, 0)));
    vecs.push_back(mk(0, 1, 4'b0000, ex(4'b0000, 2'd2, 0, 0)));  // idle keeps last id
    vecs.push_back(mk(0, 1, 4'b0010, ex(4'b0010, 2'd1, 1, 0)));  // search from ptr=3
    vecs.push_back(mk(0, 1, 4'b0000, ex(4'b0000, 2'd1, 0, 0)));

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].ena, vecs[i].req, vecs[i].exp);
    end

    // Hold-timeout sequence with two requesters held.
    step("to_rst", 1, 1, 4'b0000, ex(4'b0000, 2'd0, 0, 0));
    for (int c = 0; c < 10; c++) begin
      if (TO_EN && c >= 8)
        step($sformatf("to_pair%0d", c), 0, 1, 4'b0011, ex(4'b0010, 2'd1, 1, (c == 8)));
      else
        step($sformatf("to_pair%0d", c), 0, 1, 4'b0011, ex(4'b0001, 2'd0, 1, 0));
    end

    // Lone requester: no rotation however long it holds.
    for (int c = 0; c < 12; c++) begin
      step($sformatf("to_solo%0d", c), 0, 1, 4'b0001, ex(4'b0001, 2'd0, 1, 0));
    end

    // Competitor arrives after the counter has saturated.
    if (TO_EN) begin
      step("to_late", 0, 1, 4'b0011, ex(4'b0010, 2'd1, 1, 1));
      step("to_late1", 0, 1, 4'b0011, ex(4'b0010, 2'd1, 1, 0));
    end else begin
      step("to_late", 0, 1, 4'b0011, ex(4'b0001, 2'd0, 1, 0));
      step("to_late1", 0, 1, 4'b0011, ex(4'b0001, 2'd0, 1, 0));
    end

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters; legal values 2, 4, 8.
REQ-002 SHALL have parameter MAX_HOLD, default 8: maximum grant tenure in cycles when the timeout feature is compiled in; legal range 2..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port ena, input, 1 bit: global enable.
REQ-006 SHALL have port req, input, N bits: request vector; bit i belongs to requester i.
REQ-007 SHALL have port gnt, output, N bits: grant vector, one-hot or all-zero.
REQ-008 SHALL have port gnt_id, output, $clog2(N) bits: binary index of the current owner.
REQ-009 SHALL have port gnt_valid, output, 1 bit: high while an owner exists (state GRANT).
REQ-010 SHALL have port timeout, output, 1 bit: one-cycle pulse on forced rotation.

Function
REQ-011 SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-012 SHALL search for a winner starting at rotating pointer ptr, checking ptr, ptr+1, ... mod N; the first set req bit wins.
REQ-013 In IDLE with ena=1 and req!=0 at edge k, SHALL enter GRANT with gnt_id=winner and gnt_valid=1 from cycle k+1 (1-cycle latency).
REQ-014 In IDLE with req=0 or ena=0, SHALL remain in IDLE.
REQ-015 In GRANT, SHALL hold gnt_id while req[gnt_id]=1.
REQ-016 In GRANT, when req[gnt_id]=0 at edge k, SHALL search the remaining requesters (owner excluded) from ptr.
  - If a winner exists, gnt switches directly to it at k+1 with no idle cycle.
  - Otherwise the FSM enters IDLE at k+1.
REQ-017 On every new grant, SHALL set ptr to (winner+1) mod N; wrap from N-1 to 0 is required.
REQ-018 SHALL drive gnt = onehot(gnt_id) when gnt_valid=1 and ena=1, and 0 otherwise; gnt is combinational from registered state.
REQ-019 With ena=0 in GRANT, SHALL force gnt=0 and freeze state, ptr and hold counter; the previous grant reappears when ena returns to 1.
REQ-020 A release and a new request from the same requester in the same cycle SHALL be treated as a release (owner excluded from the search).
REQ-021 SHALL keep gnt_id stable (last owner) while in IDLE.

Reset
REQ-022 On rst=1 at a rising edge, SHALL set state=IDLE, ptr=0, gnt_id=0, gnt_valid=0, hold counter=0 and timeout=0; gnt is therefore 0.
REQ-023 rst SHALL take priority over all other inputs, including mid-tenure; the first grant after reset SHALL be searched from index 0.

Configuration
REQ-024 SHALL use macro ARB_TIMEOUT_EN.
REQ-025 With ARB_TIMEOUT_EN defined:
  - an 8-bit hold counter increments each enabled cycle in GRANT and clears on each new grant;
  - when the counter reaches MAX_HOLD-1 and any other requester is pending, the grant SHALL rotate at the next edge as in REQ-016, with timeout=1 for that one cycle;
  - if no other requester is pending, the grant is kept and the counter saturates.
REQ-026 Without ARB_TIMEOUT_EN, SHALL build no counter and tie timeout to 0; the timeout port is kept in both builds.

Structure
REQ-027 Package arb_pkg SHALL hold typedef arb_state_t (ARB_IDLE, ARB_GRANT) and constant ARB_N_DEFAULT=4.
REQ-028 SHALL instantiate one sub-module, grant_decoder: binary-to-one-hot with enable, built from decoder_1_to_2 stages, producing gnt.

Verification
REQ-029 Reset, then req=4'b1010 -> next cycle gnt=4'b0010, gnt_id=1, gnt_valid=1.
REQ-030 Owner 1 drops req with req=4'b1000 pending -> next cycle gnt=4'b1000 with no gap; owner 3 then drops with req=4'b0001 -> gnt=4'b0001 (wrap).
REQ-031 req=4'b1111 held and each owner releasing for one cycle -> grant order 0,1,2,3,0.
REQ-032 In GRANT, ena=0 for 3 cycles -> gnt=0 for those cycles, then the same one-hot value is restored; rst=1 mid-tenure -> next cycle gnt=0 and gnt_valid=0.
REQ-033 ARB_TIMEOUT_EN, MAX_HOLD=8, req=4'b0011 held -> owner 0 for 8 cycles, then gnt=4'b0010 with a one-cycle timeout pulse; req=4'b0001 alone -> no rotation and timeout=0.
